// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared types and constants for the RAM/I/O read-decode stage
package ram_rd_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef enum logic [1:0] {CLS_RAM, CLS_IO, CLS_ERR} cls_t;

  localparam int CNT_W = 4;

  // Index width for n entries; a single entry still needs one bit of index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_rd_ctl_if.sv
// rtl/ram_rd_ctl_if.sv - CPU read bus between requester and read-decode stage
interface ram_rd_ctl_if #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int NWORDS = 8,
  parameter int NIO    = 2
);
  logic                 RD_REQ;
  logic [AW-1:0]        RAM_AD_IN;
  logic [NWORDS*DW-1:0] RAM_IN;
  logic [NIO*DW-1:0]    IO_IN;
  logic                 BUSY;
  logic                 RD_ACK;
  logic [AW-1:0]        RAM_AD_OUT;
  logic [DW-1:0]        RAM_OUT;
  logic                 RD_ERR;

  modport master (
    output RD_REQ, RAM_AD_IN, RAM_IN, IO_IN,
    input  BUSY, RD_ACK, RAM_AD_OUT, RAM_OUT, RD_ERR
  );

  modport slave (
    input  RD_REQ, RAM_AD_IN, RAM_IN, IO_IN,
    output BUSY, RD_ACK, RAM_AD_OUT, RAM_OUT, RD_ERR
  );
endinterface

// File: rtl/ram_rd_decode.sv
// rtl/ram_rd_decode.sv - combinational address to class and index decoder
module ram_rd_decode
  import ram_rd_pkg::*;
#(
  parameter int AW      = 8,
  parameter int NWORDS  = 8,
  parameter int NIO     = 2,
  parameter int IO_BASE = 'h40,
  parameter int RW      = idx_w(NWORDS),
  parameter int IW      = idx_w(NIO)
) (
  input  logic [AW-1:0] addr,
  output cls_t          cls,
  output logic [RW-1:0] ram_idx,
  output logic [IW-1:0] io_idx
);

  // One extra bit keeps the compares free of wrap-around at the top of the map.
  localparam logic [AW:0] NW_X  = (AW+1)'(NWORDS);
  localparam logic [AW:0] IOB_X = (AW+1)'(IO_BASE);
  localparam logic [AW:0] NIO_X = (AW+1)'(NIO);

  logic [AW:0] a_x;
  logic [AW:0] off_x;

  assign a_x   = {1'b0, addr};
  assign off_x = a_x - IOB_X;

  always_comb begin
    cls     = CLS_ERR;
    ram_idx = '0;
    io_idx  = '0;
    if (a_x < NW_X) begin
      cls     = CLS_RAM;
      ram_idx = addr[RW-1:0];
    end else if ((a_x >= IOB_X) && (off_x < NIO_X)) begin
      cls    = CLS_IO;
      io_idx = off_x[IW-1:0];
    end
  end

endmodule

// File: rtl/ram_rd_ctl.sv
// rtl/ram_rd_ctl.sv - read-decode stage with I/O wait states and decode-error flag
module ram_rd_ctl
  import ram_rd_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 8,
  parameter int NWORDS  = 8,
  parameter int NIO     = 2,
  parameter int IO_BASE = 'h40,
  parameter int IO_WAIT = 1
) (
  input logic         CLK_DC,
  input logic         N_RESET,
  ram_rd_ctl_if.slave bus
);

  localparam int RW = idx_w(NWORDS);
  localparam int IW = idx_w(NIO);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [IW-1:0]     io_idx_q, io_idx_n;
  logic [DW-1:0]     out_q;
  logic [AW-1:0]     ad_q;
  logic              err_q;

  cls_t              d_cls;
  logic [RW-1:0]     d_ram_idx;
  logic [IW-1:0]     d_io_idx;

  logic              load;
  logic [DW-1:0]     sel_data;
  logic [AW-1:0]     sel_addr;
  logic              sel_err;

  ram_rd_decode #(
    .AW      (AW),
    .NWORDS  (NWORDS),
    .NIO     (NIO),
    .IO_BASE (IO_BASE),
    .RW      (RW),
    .IW      (IW)
  ) u_decode (
    .addr    (bus.RAM_AD_IN),
    .cls     (d_cls),
    .ram_idx (d_ram_idx),
    .io_idx  (d_io_idx)
  );

  // load marks the single cycle that enters DONE; output registers capture then.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    addr_n   = addr_q;
    io_idx_n = io_idx_q;
    load     = 1'b0;
    sel_data = '0;
    sel_addr = addr_q;
    sel_err  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.RD_REQ) begin
          addr_n   = bus.RAM_AD_IN;
          io_idx_n = d_io_idx;
          sel_addr = bus.RAM_AD_IN;
          case (d_cls)
            CLS_RAM: begin
              sel_data = bus.RAM_IN[d_ram_idx*DW +: DW];
              load     = 1'b1;
              state_n  = DONE;
            end
            CLS_IO: begin
              if (IO_WAIT == 0) begin
                sel_data = bus.IO_IN[d_io_idx*DW +: DW];
                load     = 1'b1;
                state_n  = DONE;
              end else begin
                cnt_n   = CNT_W'(IO_WAIT);
                state_n = WAIT;
              end
            end
            default: begin
              sel_err = 1'b1;
              load    = 1'b1;
              state_n = DONE;
            end
          endcase
        end
      end
      WAIT: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          sel_data = bus.IO_IN[io_idx_q*DW +: DW];
          load     = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_DC) begin
    if (!N_RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      io_idx_q <= '0;
      out_q    <= '0;
      ad_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      addr_q   <= addr_n;
      io_idx_q <= io_idx_n;
      if (load) begin
        out_q <= sel_data;
        ad_q  <= sel_addr;
        err_q <= sel_err;
      end
    end
  end

  assign bus.BUSY       = (state != IDLE);
  assign bus.RD_ACK     = (state == DONE);
  assign bus.RAM_AD_OUT = ad_q;
  assign bus.RAM_OUT    = out_q;
  assign bus.RD_ERR     = err_q;

endmodule

// File: tb/tb_ram_rd_ctl.sv
// tb/tb_ram_rd_ctl.sv - directed self-checking bench for ram_rd_ctl
module tb_ram_rd_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int checks = 0;
  int errors = 0;

  ram_rd_ctl_if #(.DW(16), .AW(8), .NWORDS(8), .NIO(2)) b0 ();
  ram_rd_ctl_if #(.DW(16), .AW(8), .NWORDS(8), .NIO(2)) b1 ();
  ram_rd_ctl_if #(.DW(8),  .AW(8), .NWORDS(1), .NIO(1)) b2 ();

  ram_rd_ctl #(.DW(16), .AW(8), .NWORDS(8), .NIO(2), .IO_BASE('h40), .IO_WAIT(1))
    u0 (.CLK_DC(clk), .N_RESET(rst0), .bus(b0));
  ram_rd_ctl #(.DW(16), .AW(8), .NWORDS(8), .NIO(2), .IO_BASE('h40), .IO_WAIT(3))
    u1 (.CLK_DC(clk), .N_RESET(rst1), .bus(b1));
  ram_rd_ctl #(.DW(8), .AW(8), .NWORDS(1), .NIO(1), .IO_BASE('h40), .IO_WAIT(0))
    u2 (.CLK_DC(clk), .N_RESET(rst2), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Single-cycle read on u0; starts and ends at a negedge with the FSM idle.
  task automatic rd0(input string tag, input logic [7:0] a, input logic [15:0] d, input logic e);
    b0.RD_REQ = 1'b1;
    b0.RAM_AD_IN = a;
    @(negedge clk);
    b0.RD_REQ = 1'b0;
    check({tag, ".ack"},  32'(b0.RD_ACK), 32'd1);
    check({tag, ".busy"}, 32'(b0.BUSY), 32'd1);
    check({tag, ".data"}, 32'(b0.RAM_OUT), 32'(d));
    check({tag, ".addr"}, 32'(b0.RAM_AD_OUT), 32'(a));
    check({tag, ".err"},  32'(b0.RD_ERR), 32'(e));
    @(negedge clk);
    check({tag, ".ack_end"}, 32'(b0.RD_ACK), 32'd0);
  endtask

  task automatic rd2(input string tag, input logic [7:0] a, input logic [7:0] d, input logic e);
    b2.RD_REQ = 1'b1;
    b2.RAM_AD_IN = a;
    @(negedge clk);
    b2.RD_REQ = 1'b0;
    check({tag, ".ack"},  32'(b2.RD_ACK), 32'd1);
    check({tag, ".data"}, 32'(b2.RAM_OUT), 32'(d));
    check({tag, ".addr"}, 32'(b2.RAM_AD_OUT), 32'(a));
    check({tag, ".err"},  32'(b2.RD_ERR), 32'(e));
    @(negedge clk);
    check({tag, ".ack_end"}, 32'(b2.RD_ACK), 32'd0);
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    b0.RD_REQ = 1'b0; b0.RAM_AD_IN = '0;
    b1.RD_REQ = 1'b0; b1.RAM_AD_IN = '0;
    b2.RD_REQ = 1'b0; b2.RAM_AD_IN = '0;
    for (int i = 0; i < 8; i++) begin
      b0.RAM_IN[i*16 +: 16] = 16'h1000 + 16'(i);
      b1.RAM_IN[i*16 +: 16] = 16'h2000 + 16'(i);
    end
    b0.RAM_IN[3*16 +: 16] = 16'hA5A5;
    b0.IO_IN = {16'h1111, 16'h0BAD};
    b1.IO_IN = {16'h7777, 16'hCAFE};
    b2.RAM_IN = 8'h5A;
    b2.IO_IN  = 8'hC3;

    repeat (2) @(negedge clk);
    check("rst.busy", 32'(b0.BUSY), 32'd0);
    check("rst.ack",  32'(b0.RD_ACK), 32'd0);
    check("rst.addr", 32'(b0.RAM_AD_OUT), 32'd0);
    check("rst.data", 32'(b0.RAM_OUT), 32'd0);
    check("rst.err",  32'(b0.RD_ERR), 32'd0);
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    @(negedge clk);

    rd0("ram3", 8'h03, 16'hA5A5, 1'b0);
    check("ram3.hold", 32'(b0.RAM_OUT), 32'hA5A5);

    // I/O channel 1 changes during the wait; the late value must be returned.
    b0.RD_REQ = 1'b1;
    b0.RAM_AD_IN = 8'h41;
    @(negedge clk);
    b0.RD_REQ = 1'b0;
    b0.IO_IN[31:16] = 16'h2222;
    check("io.wait_ack",  32'(b0.RD_ACK), 32'd0);
    check("io.wait_busy", 32'(b0.BUSY), 32'd1);
    @(negedge clk);
    check("io.ack",  32'(b0.RD_ACK), 32'd1);
    check("io.data", 32'(b0.RAM_OUT), 32'h2222);
    check("io.addr", 32'(b0.RAM_AD_OUT), 32'h41);
    check("io.err",  32'(b0.RD_ERR), 32'd0);
    @(negedge clk);
    check("io.idle", 32'(b0.BUSY), 32'd0);

    rd0("unm20", 8'h20, 16'h0000, 1'b1);
    check("unm20.err_hold", 32'(b0.RD_ERR), 32'd1);
    rd0("ram0",  8'h00, 16'h1000, 1'b0);
    rd0("ram7",  8'h07, 16'h1007, 1'b0);
    rd0("unm08", 8'h08, 16'h0000, 1'b1);
    rd0("unm3f", 8'h3F, 16'h0000, 1'b1);
    rd0("unm42", 8'h42, 16'h0000, 1'b1);
    rd0("unmff", 8'hFF, 16'h0000, 1'b1);

    b0.RD_REQ = 1'b1;
    b0.RAM_AD_IN = 8'h01;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("held.ack%0d", k),  32'(b0.RD_ACK), 32'(k % 2));
      check($sformatf("held.busy%0d", k), 32'(b0.BUSY), 32'(k % 2));
    end
    b0.RD_REQ = 1'b0;
    check("held.data", 32'(b0.RAM_OUT), 32'h1001);
    @(negedge clk);
    check("held.end_ack", 32'(b0.RD_ACK), 32'd0);

    // u1: a completed read, then reset while an I/O read sits in WAIT.
    b1.RD_REQ = 1'b1;
    b1.RAM_AD_IN = 8'h02;
    @(negedge clk);
    b1.RD_REQ = 1'b0;
    check("u1.ram2", 32'(b1.RAM_OUT), 32'h2002);
    @(negedge clk);
    b1.RD_REQ = 1'b1;
    b1.RAM_AD_IN = 8'h40;
    @(negedge clk);
    check("abort.busy", 32'(b1.BUSY), 32'd1);
    check("abort.ack",  32'(b1.RD_ACK), 32'd0);
    rst1 = 1'b0;
    @(negedge clk);
    check("abort.rst_busy", 32'(b1.BUSY), 32'd0);
    check("abort.rst_ack",  32'(b1.RD_ACK), 32'd0);
    check("abort.rst_addr", 32'(b1.RAM_AD_OUT), 32'd0);
    check("abort.rst_data", 32'(b1.RAM_OUT), 32'd0);
    check("abort.rst_err",  32'(b1.RD_ERR), 32'd0);
    @(negedge clk);
    check("abort.req_ovr", 32'(b1.BUSY), 32'd0);
    rst1 = 1'b1;
    b1.RD_REQ = 1'b0;
    @(negedge clk);
    b1.RD_REQ = 1'b1;
    b1.RAM_AD_IN = 8'h40;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b1.RD_REQ = 1'b0;
      check($sformatf("io3.ack%0d", k), 32'(b1.RD_ACK), 32'(k == 4));
    end
    check("io3.data", 32'(b1.RAM_OUT), 32'hCAFE);
    check("io3.addr", 32'(b1.RAM_AD_OUT), 32'h40);
    check("io3.err",  32'(b1.RD_ERR), 32'd0);

    rd2("sw.ram0", 8'h00, 8'h5A, 1'b0);
    rd2("sw.io40", 8'h40, 8'hC3, 1'b0);
    rd2("sw.unm1", 8'h01, 8'h00, 1'b1);
    rd2("sw.unm41", 8'h41, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_rd_ctl.md
# ram_rd_ctl

Parametrised read-decode stage between the CPU address bus and the register-file RAM and I/O input ports; successor to the fixed 8-word, single-I/O read decoder. It accepts a read request, decodes the address into RAM, I/O or unmapped space, and applies a programmable wait-state count to I/O reads. It returns registered data with a one-cycle acknowledge pulse and a decode-error flag, so unmapped reads are explicit instead of producing don't-care data.

## Interface
- DW, 16, data width of RAM words and I/O ports
- AW, 8, address width
- NWORDS, 8, number of RAM words, mapped at addresses 0 .. NWORDS-1; must be at least 1 and NWORDS ≤ IO_BASE
- NIO, 2, number of I/O input channels, mapped at IO_BASE .. IO_BASE+NIO-1
- IO_BASE, 8'h40, first I/O address; IO_BASE+NIO ≤ 2**AW
- IO_WAIT, 1, extra wait cycles before an I/O sample, 0..15

Ports:
- CLK_DC  in  1  clock, rising edge
- N_RESET  in  1  synchronous active-low reset
- RD_REQ  in  1  read request, sampled when BUSY=0
- RAM_AD_IN  in  AW  read address, sampled with RD_REQ
- RAM_IN  in  NWORDS*DW  flattened RAM words; word i is at bits [i*DW +: DW]
- IO_IN  in  NIO*DW  flattened I/O channels; channel j is at bits [j*DW +: DW]
- BUSY  out  1  a request is in progress; new requests are ignored
- RD_ACK  out  1  one-cycle pulse; RAM_OUT, RAM_AD_OUT and RD_ERR are valid
- RAM_AD_OUT  out  AW  address of the completed read
- RAM_OUT  out  DW  read data; holds until the next RD_ACK
- RD_ERR  out  1  the completed read was unmapped; valid with RD_ACK and held after it

## Operation
- Address decode classes:
  - RAM: address < NWORDS
  - IO: IO_BASE ≤ address < IO_BASE+NIO
  - ERR: any other address
- FSM states IDLE, WAIT, DONE. Reset enters IDLE.
- IDLE:
  - RD_REQ=0: stay in IDLE.
  - RD_REQ=1 with a RAM or ERR address: latch the address and go to DONE.
  - RD_REQ=1 with an IO address and IO_WAIT=0: go to DONE.
  - RD_REQ=1 with an IO address and IO_WAIT>0: load the wait counter with IO_WAIT and go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to DONE.
- DONE:
  - RAM_OUT takes the selected data: the RAM word, the IO channel, or 0 for ERR.
  - RAM_AD_OUT takes the latched address and RD_ERR takes the ERR class.
  - RD_ACK=1 for exactly this one cycle, then return to IDLE.
- Data sampling:
  - RAM data is sampled from RAM_IN in the IDLE→DONE transition cycle.
  - IO data is sampled from IO_IN in the cycle that enters DONE, i.e. the last cycle of the wait, not at request time.
- BUSY=1 in WAIT and DONE. RD_REQ is ignored whenever BUSY=1; no queueing.
- Width rules:
  - The IO channel index is address−IO_BASE, truncated to $clog2(NIO) bits (minimum 1 bit).
  - An out-of-range index cannot occur because the decode class excludes it.

## Timing
- Reset values: BUSY=0, RD_ACK=0, RAM_AD_OUT=0, RAM_OUT=0, RD_ERR=0, wait counter=0, FSM=IDLE.
- Latency from the request cycle to the RD_ACK cycle:
  - RAM or ERR reads: 1 cycle.
  - IO reads: 1+IO_WAIT cycles.
- Back-to-back: a new request is accepted in the cycle after RD_ACK. Peak rate is one RAM read every 2 cycles.
- A request in the same cycle as RD_ACK is ignored (BUSY=1).
- Reset mid-operation, in WAIT or DONE: the next edge forces every output to its reset value. No RD_ACK is emitted for the aborted read.
- N_RESET=0 overrides RD_REQ in the same cycle.
- An address at 2**AW−1 decodes normally; the decode has no wrap-around.

## Structure
- Shared package ram_rd_pkg:
  - FSM state enum (IDLE, WAIT, DONE).
  - Decode-class enum (CLS_RAM, CLS_IO, CLS_ERR).
  - Wait-counter width constant (4).
- Natural sub-module: ram_rd_decode, a combinational address→class and index decoder. It is reused by the write-side decoder.
- The wait counter and FSM live in ram_rd_ctl.

## Test plan
- Reset, then a RAM read: RAM_IN word 3 = 16'hA5A5, RD_REQ with address 8'h03 → RD_ACK one cycle later, RAM_OUT=16'hA5A5, RAM_AD_OUT=8'h03, RD_ERR=0.
- IO read with IO_WAIT=1: IO_IN changes from 16'h1111 to 16'h2222 one cycle after a request to address 8'h41 → RD_ACK 2 cycles after the request, RAM_OUT=16'h2222.
- Unmapped read to address 8'h20 → RD_ACK after 1 cycle, RAM_OUT=0, RD_ERR=1. A following read to address 8'h00 clears RD_ERR.
- RD_REQ held high for 6 cycles to address 8'h01 → RD_ACK in cycles 1, 3 and 5 only; BUSY alternates.
- N_RESET asserted while in WAIT (IO_WAIT=3) → no RD_ACK, all outputs 0 on the next edge, and the next request behaves as one issued from IDLE.
- Parameter sweep with NWORDS=1, NIO=1, DW=8, IO_WAIT=0: address 0 and address IO_BASE each produce RD_ACK after 1 cycle; address 1 sets RD_ERR.
